// File: rtl/syndrome_lal32.sv
// Parallel RS(544,514) syndrome calculator over GF(2^10), M symbols per beat, J lanes.
// Block Horner: acc_j <= acc_j * alpha^(jM) ^ sum_m data[m] * alpha^(jm).

package rs544_syndrome_consts_M32_pkg;

  localparam int J_MAX  = 22;
  localparam int M_BEAT = 32;

  typedef logic [9:0]                          gf_t;
  typedef logic [J_MAX-1:0][M_BEAT-1:0][9:0]   wfwd_t;
  typedef logic [J_MAX-1:0][9:0]               fb_t;
  typedef logic [9:0][9:0]                     cols_t;

  // Reduction uses x^10 = x^3 + 1 (primitive poly 0x409).
  function automatic gf_t gf_mul(input gf_t a, input gf_t b);
    gf_t p;
    p = '0;
    for (int i = 9; i >= 0; i--) begin
      p = {p[8:0], 1'b0} ^ (p[9] ? 10'h009 : 10'h000);
      if (b[i]) p = p ^ a;
    end
    return p;
  endfunction

  function automatic gf_t gf_pow_alpha(input int unsigned e);
    gf_t         r;
    gf_t         base;
    int unsigned x;
    r    = 10'h001;
    base = 10'h002;
    x    = e % 1023;
    for (int i = 0; i < 10; i++) begin
      if (((x >> i) & 1) != 0) r = gf_mul(r, base);
      base = gf_mul(base, base);
    end
    return r;
  endfunction

  function automatic wfwd_t gen_weight_fwd();
    wfwd_t w;
    for (int k = 0; k < J_MAX; k++)
      for (int m = 0; m < M_BEAT; m++)
        w[k][m] = gf_pow_alpha(unsigned'((k + 1) * m));
    return w;
  endfunction

  function automatic fb_t gen_feedback();
    fb_t f;
    for (int k = 0; k < J_MAX; k++)
      f[k] = gf_pow_alpha(unsigned'((k + 1) * M_BEAT));
    return f;
  endfunction

  // Column i of the constant multiplier matrix is C * alpha^i.
  function automatic cols_t gen_mul_cols(input gf_t c);
    cols_t cols;
    for (int i = 0; i < 10; i++) cols[i] = gf_mul(c, gf_pow_alpha(unsigned'(i)));
    return cols;
  endfunction

  localparam wfwd_t WEIGHT_FWD = gen_weight_fwd();
  localparam fb_t   FEEDBACK   = gen_feedback();

endpackage

module gf10_const_mul_by_param #(
  parameter logic [9:0] C = 10'h001
) (
  input  logic [9:0] x,
  output logic [9:0] y
);
  import rs544_syndrome_consts_M32_pkg::*;

  localparam cols_t COLS = gen_mul_cols(C);

  always_comb begin
    // NOTE: assigning a default before the loop keeps every path driven, so no latch is inferred.
    y = '0;
    for (int i = 0; i < 10; i++)
      if (x[i]) y = y ^ COLS[i];
  end
endmodule

module syndrome_lal32 #(
  parameter int J = 22,
  parameter int M = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                valid_i,
  input  logic                start_i,
  input  logic                last_i,
  input  logic [M-1:0][9:0]   data_i,
  output logic                s_valid_o,
  output logic [J-1:0][9:0]   s_o
);
  import rs544_syndrome_consts_M32_pkg::*;

  logic [9:0]         prod    [J][M];
  logic [9:0]         fb_prod [J];
  logic [J-1:0][9:0]  acc_q;
  logic [J-1:0][9:0]  acc_next;

  for (genvar k = 0; k < J; k++) begin : g_lane
    for (genvar m = 0; m < M; m++) begin : g_sym
      gf10_const_mul_by_param #(.C(WEIGHT_FWD[k][m])) u_wmul (
        .x(data_i[m]),
        .y(prod[k][m])
      );
    end
    gf10_const_mul_by_param #(.C(FEEDBACK[k])) u_fbmul (
      .x(acc_q[k]),
      .y(fb_prod[k])
    );
  end

  // start_i drops the feedback term so a new codeword discards prior state.
  always_comb begin
    acc_next = '0;
    for (int k = 0; k < J; k++) begin
      acc_next[k] = start_i ? 10'h000 : fb_prod[k];
      for (int m = 0; m < M; m++) acc_next[k] = acc_next[k] ^ prod[k][m];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q     <= '0;
      s_o       <= '0;
      s_valid_o <= 1'b0;
    end else if (valid_i) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
      acc_q     <= acc_next;
      s_o       <= acc_next;
      s_valid_o <= last_i;
    end else begin
      s_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_syndrome_lal32.sv
// Self-checking bench for syndrome_lal32: serial Horner reference model feeding a result scoreboard.
module tb_syndrome_lal32;

  localparam int J     = 22;
  localparam int M     = 32;
  localparam int N     = 544;
  localparam int BEATS = 17;

  typedef logic [9:0]        sym_t;
  typedef sym_t              cw_t [N];
  typedef logic [J-1:0][9:0] syn_t;

  logic              clk_i   = 1'b0;
  logic              rst_ni  = 1'b0;
  logic              valid_i = 1'b0;
  logic              start_i = 1'b0;
  logic              last_i  = 1'b0;
  logic [M-1:0][9:0] data_i  = '0;
  logic              s_valid_o;
  syn_t              s_o;

  int   total  = 0;
  int   bad    = 0;
  int   pulses = 0;
  syn_t sb [$];

  always #5 clk_i = ~clk_i;

  syndrome_lal32 #(.J(J), .M(M)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .start_i  (start_i),
    .last_i   (last_i),
    .data_i   (data_i),
    .s_valid_o(s_valid_o),
    .s_o      (s_o)
  );

  function automatic sym_t mul(input sym_t a, input sym_t b);
    sym_t p = '0;
    for (int i = 0; i < 10; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[8:0], 1'b0} ^ (a[9] ? 10'h009 : 10'h000);
    end
    return p;
  endfunction

  function automatic sym_t apow(input int e);
    sym_t r = 10'h001;
    repeat (e % 1023) r = mul(r, 10'h002);
    return r;
  endfunction

  // Serial Horner over all 544 symbols, highest degree first.
  function automatic syn_t horner(input cw_t r);
    syn_t s;
    for (int k = 0; k < J; k++) begin
      sym_t aj  = apow(k + 1);
      sym_t acc = '0;
      for (int d = N - 1; d >= 0; d--) acc = mul(acc, aj) ^ r[d];
      s[k] = acc;
    end
    return s;
  endfunction

  function automatic cw_t zero_cw();
    cw_t r;
    for (int d = 0; d < N; d++) r[d] = '0;
    return r;
  endfunction

  function automatic cw_t rand_cw();
    cw_t r;
    for (int d = 0; d < N; d++) r[d] = sym_t'($urandom_range(0, 1023));
    return r;
  endfunction

  // Systematic encoder with generator roots alpha^1..alpha^30.
  function automatic cw_t encode_cw();
    cw_t  r;
    sym_t g [31];
    sym_t p [30];
    sym_t root, msg, fb;
    for (int i = 0; i < 31; i++) g[i] = '0;
    g[0] = 10'h001;
    for (int i = 1; i <= 30; i++) begin
      root = apow(i);
      for (int d = i; d >= 1; d--) g[d] = g[d-1] ^ mul(g[d], root);
      g[0] = mul(g[0], root);
    end
    for (int i = 0; i < 30; i++) p[i] = '0;
    for (int d = N - 1; d >= 30; d--) begin
      msg  = sym_t'($urandom_range(0, 1023));
      r[d] = msg;
      fb   = msg ^ p[29];
      for (int i = 29; i >= 1; i--) p[i] = p[i-1] ^ mul(fb, g[i]);
      p[0] = mul(fb, g[0]);
    end
    for (int i = 0; i < 30; i++) r[i] = p[i];
    return r;
  endfunction

  // Scoreboard consumer: every pulse must match the oldest expected result.
  always @(negedge clk_i) begin
    if (rst_ni && s_valid_o) begin
      syn_t exp_s;
      pulses++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse got=%h exp=<none>", s_o);
      end else begin
        exp_s = sb.pop_front();
        if (s_o !== exp_s) begin
          bad++;
          $display("FAIL syndrome_result got=%h exp=%h", s_o, exp_s);
        end
      end
    end
  end

  task automatic drive_beat(input cw_t r, input int c, input bit st, input bit la);
    @(negedge clk_i);
    valid_i = 1'b1;
    start_i = st;
    last_i  = la;
    for (int m = 0; m < M; m++) data_i[m] = r[512 - 32 * c + m];
  endtask

  // Idle cycles carry junk on data/start/last to show they are ignored without valid_i.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_i);
      valid_i = 1'b0;
      start_i = 1'($urandom_range(0, 1));
      last_i  = 1'($urandom_range(0, 1));
      for (int m = 0; m < M; m++) data_i[m] = sym_t'($urandom_range(0, 1023));
    end
  endtask

  task automatic send_cw(input cw_t r, input bit gaps);
    for (int c = 0; c < BEATS; c++) begin
      if (gaps) idle($urandom_range(0, 3));
      drive_beat(r, c, c == 0, c == BEATS - 1);
    end
  endtask

  task automatic check_pulse(input string name);
    @(negedge clk_i);
    valid_i = 1'b0;
    start_i = 1'b0;
    last_i  = 1'b0;
    total++;
    if (s_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL %s_pulse_rise got=%b exp=1", name, s_valid_o);
    end
    @(negedge clk_i);
    total++;
    if (s_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL %s_pulse_fall got=%b exp=0", name, s_valid_o);
    end
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (s_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid got=%b exp=0", s_valid_o);
    end
    total++;
    if (s_o !== '0) begin
      bad++;
      $display("FAIL reset_s got=%h exp=0", s_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle(2);
  endtask

  task automatic test_zero();
    sb.push_back('0);
    send_cw(zero_cw(), 1'b0);
    check_pulse("zero");
  endtask

  task automatic test_last_symbol();
    cw_t  r = zero_cw();
    syn_t e;
    r[0] = 10'h001;
    for (int k = 0; k < J; k++) e[k] = 10'h001;
    sb.push_back(e);
    send_cw(r, 1'b0);
    check_pulse("last_symbol");
  endtask

  task automatic test_alpha();
    cw_t r = zero_cw();
    r[1] = 10'h001;
    sb.push_back(horner(r));
    send_cw(r, 1'b0);
    check_pulse("alpha");
    total++;
    if (s_o[0] !== 10'h002) begin
      bad++;
      $display("FAIL alpha_s1 got=%h exp=002", s_o[0]);
    end
    total++;
    if (s_o[1] !== 10'h004) begin
      bad++;
      $display("FAIL alpha_s2 got=%h exp=004", s_o[1]);
    end
    total++;
    if (s_o[9] !== 10'h009) begin
      bad++;
      $display("FAIL alpha_s10 got=%h exp=009", s_o[9]);
    end
  endtask

  task automatic test_codeword();
    sb.push_back('0);
    send_cw(encode_cw(), 1'b0);
    check_pulse("codeword");
  endtask

  task automatic test_two_error();
    cw_t  r = encode_cw();
    syn_t e;
    r[37]  = r[37]  ^ 10'h155;
    r[500] = r[500] ^ sym_t'($urandom_range(1, 1023));
    e = horner(r);
    sb.push_back(e);
    send_cw(r, 1'b0);
    check_pulse("two_error");
    sb.push_back(e);
    send_cw(r, 1'b1);
    check_pulse("two_error_gaps");
  endtask

  task automatic test_single_beat();
    cw_t r = zero_cw();
    for (int d = 0; d < M; d++) r[d] = sym_t'($urandom_range(0, 1023));
    sb.push_back(horner(r));
    drive_beat(r, BEATS - 1, 1'b1, 1'b1);
    check_pulse("single_beat");
  endtask

  task automatic test_reset_mid();
    cw_t r1 = rand_cw();
    cw_t r2 = rand_cw();
    for (int c = 0; c <= 8; c++) drive_beat(r1, c, c == 0, 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    total++;
    if (s_o !== '0) begin
      bad++;
      $display("FAIL midreset_s got=%h exp=0", s_o);
    end
    total++;
    if (s_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL midreset_valid got=%b exp=0", s_valid_o);
    end
    @(negedge clk_i);
    valid_i = 1'b0;
    rst_ni  = 1'b1;
    idle(1);
    sb.push_back(horner(r2));
    send_cw(r2, 1'b0);
    check_pulse("after_reset");
  endtask

  task automatic test_back_to_back();
    cw_t r1 = rand_cw();
    cw_t r2 = rand_cw();
    int  p0;
    sb.push_back(horner(r1));
    sb.push_back(horner(r2));
    p0 = pulses;
    send_cw(r1, 1'b0);
    send_cw(r2, 1'b0);
    check_pulse("back_to_back");
    total++;
    if (pulses - p0 !== 2) begin
      bad++;
      $display("FAIL b2b_pulse_count got=%0d exp=2", pulses - p0);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_last_symbol();
    test_alpha();
    test_codeword();
    test_two_error();
    test_single_beat();
    test_reset_mid();
    test_back_to_back();
    idle(3);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
